// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: tags each word with AdEL ExcCode and
// branch-delay-slot flag. Define FQ_BYPASS_EN to forward into an empty queue.
module fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    output logic        f_ready,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic [4:0]  d_exccode,
    output logic        d_bd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    function automatic logic pc_illegal(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < PC_LO) || (pc > PC_HI);
    endfunction

    function automatic logic is_branch(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        logic       br;
        op = instr[31:26];
        fn = instr[5:0];
        case (op)
            6'h01, 6'h02, 6'h03, 6'h04,
            6'h05, 6'h06, 6'h07: br = 1'b1;
            6'h00:               br = (fn == 6'h08) || (fn == 6'h09);
            default:             br = 1'b0;
        endcase
        return br;
    endfunction

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          last_br_q, last_br_d;

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];
    logic [4:0]  exc_mem_q   [DEPTH];
    logic        bd_mem_q    [DEPTH];

    logic        in_adel_s;
    logic [31:0] in_instr_s;
    logic [4:0]  in_exc_s;
    logic        in_br_s;
    logic        full_s;
    logic        empty_s;
    logic        bypass_s;
    logic        enq_s;
    logic        deq_s;
    logic        store_s;

    // An illegal fetch address is replaced by a nop so it can never look like a branch.
    assign in_adel_s  = pc_illegal(f_pc);
    assign in_instr_s = in_adel_s ? 32'h0000_0000 : f_instr;
    assign in_exc_s   = in_adel_s ? EXC_ADEL : 5'd0;
    assign in_br_s    = is_branch(in_instr_s);

    assign full_s  = (count_q == FULL_CNT);
    assign empty_s = (count_q == {CW{1'b0}});

`ifdef FQ_BYPASS_EN
    assign bypass_s = empty_s && f_valid && !flush;
    assign f_ready  = !full_s || d_ready;
`else
    assign bypass_s = 1'b0;
    assign f_ready  = !full_s;
`endif

    assign d_valid = !empty_s || bypass_s;
    assign enq_s   = f_valid && f_ready && !flush;
    assign deq_s   = !empty_s && d_ready && !flush;
    // A bypassed word taken by decode in the same cycle never lands in storage.
    assign store_s = enq_s && !(bypass_s && d_ready);

    // Next-state for counters, pointers and branch history.
    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        last_br_d = last_br_q;
        if (flush) begin
            count_d   = {CW{1'b0}};
            wr_ptr_d  = {AW{1'b0}};
            rd_ptr_d  = {AW{1'b0}};
            last_br_d = 1'b0;
        end else begin
            if (store_s && !deq_s) begin
                count_d = count_q + CW'(1);
            end else if (!store_s && deq_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
            if (store_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (enq_s) begin
                last_br_d = in_br_s;
            end else begin
                last_br_d = last_br_q;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= {CW{1'b0}};
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            last_br_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            last_br_q <= last_br_d;
        end
    end

    // Entry storage; only validity is cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (store_s) begin
            pc_mem_q[wr_ptr_q]    <= f_pc;
            instr_mem_q[wr_ptr_q] <= in_instr_s;
            exc_mem_q[wr_ptr_q]   <= in_exc_s;
            bd_mem_q[wr_ptr_q]    <= last_br_q;
        end
    end

    // Head presentation, zeroed whenever nothing valid is offered.
    always_comb begin
        d_pc      = 32'h0000_0000;
        d_instr   = 32'h0000_0000;
        d_exccode = 5'd0;
        d_bd      = 1'b0;
        if (bypass_s) begin
            d_pc      = f_pc;
            d_instr   = in_instr_s;
            d_exccode = in_exc_s;
            d_bd      = last_br_q;
        end else if (!empty_s) begin
            d_pc      = pc_mem_q[rd_ptr_q];
            d_instr   = instr_mem_q[rd_ptr_q];
            d_exccode = exc_mem_q[rd_ptr_q];
            d_bd      = bd_mem_q[rd_ptr_q];
        end else begin
            d_pc      = 32'h0000_0000;
            d_instr   = 32'h0000_0000;
            d_exccode = 5'd0;
            d_bd      = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 2;
`ifdef FQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, f_valid, d_ready;
    logic [31:0] f_pc, f_instr;
    logic        f_ready, d_valid, d_bd;
    logic [31:0] d_pc, d_instr;
    logic [4:0]  d_exccode;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
    } ent_t;

    ent_t mq[$];
    logic m_last_br = 1'b0;
    logic [5:0] br_ops [7] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07};

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_ready(f_ready),
        .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_instr(d_instr),
        .d_exccode(d_exccode), .d_bd(d_bd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic branchy(input logic [31:0] ins);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
    endfunction

    function automatic ent_t tag_word(input logic [31:0] pc, input logic [31:0] ins, input logic bd);
        ent_t e;
        bit   illegal;
        illegal = (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
        e.pc    = pc;
        e.instr = illegal ? 32'h0 : ins;
        e.exc   = illegal ? 5'd4 : 5'd0;
        e.bd    = bd;
        return e;
    endfunction

    // One clock: drive, compare against the model, then advance the model.
    task automatic step(input logic rs, input logic fl, input logic fv,
                        input logic [31:0] pc, input logic [31:0] ins, input logic dr);
        ent_t inc, head;
        int   cnt;
        bit   exp_rdy, byp, exp_vld;
        @(negedge clk);
        reset = rs; flush = fl; f_valid = fv; f_pc = pc; f_instr = ins; d_ready = dr;
        #1;
        cnt     = mq.size();
        inc     = tag_word(pc, ins, m_last_br);
        exp_rdy = (cnt != DEPTH) || (BYP && dr);
        byp     = BYP && (cnt == 0) && fv && !fl;
        exp_vld = (cnt != 0) || byp;
        head    = '{32'h0, 32'h0, 5'h0, 1'b0};
        if (byp) head = inc;
        else if (cnt != 0) head = mq[0];
        check("f_ready", 32'(f_ready), 32'(exp_rdy));
        check("d_valid", 32'(d_valid), 32'(exp_vld));
        check("d_pc", d_pc, head.pc);
        check("d_instr", d_instr, head.instr);
        check("d_exccode", 32'(d_exccode), 32'(head.exc));
        check("d_bd", 32'(d_bd), 32'(head.bd));
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
            m_last_br = 1'b0;
        end else begin
            if (exp_vld && dr && cnt != 0) void'(mq.pop_front());
            if (fv && exp_rdy) begin
                if (!(byp && dr)) mq.push_back(inc);
                m_last_br = branchy(inc.instr);
            end
        end
        #1;
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, dr);
    endtask

    task automatic enq(input logic [31:0] pc, input logic [31:0] ins);
        step(1'b0, 1'b0, 1'b1, pc, ins, 1'b0);
    endtask

    initial begin
        logic [31:0] rpc, rins;
        reset = 1'b1; flush = 1'b0; f_valid = 1'b0; f_pc = 32'h0; f_instr = 32'h0; d_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_f_ready", 32'(f_ready), 32'd1);
        check("rst_d_valid", 32'(d_valid), 32'd0);
        check("rst_d_pc", d_pc, 32'h0);
        idle(1'b0);

        // Fill to full with decode stalled.
        enq(32'h3000, 32'h24010001);
        enq(32'h3004, 32'h24020002);
        check("full_f_ready", 32'(f_ready), 32'd0);
        check("full_d_pc", d_pc, 32'h3000);
        check("full_d_instr", d_instr, 32'h24010001);
        check("full_d_exc", 32'(d_exccode), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h3008, 32'h24030003, 1'b1);
        check("deq1_d_pc", d_pc, 32'h3004);
        check("deq1_f_ready", 32'(f_ready), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // AdEL boundaries.
        enq(32'h3002, 32'h24010001);
        check("mis_exc", 32'(d_exccode), 32'd4);
        check("mis_instr", d_instr, 32'h0);
        check("mis_pc", d_pc, 32'h3002);
        idle(1'b1);
        enq(32'h7000, 32'h24010001);
        check("hi_exc", 32'(d_exccode), 32'd4);
        idle(1'b1);
        enq(32'h2FFC, 32'h24010001);
        check("lo_exc", 32'(d_exccode), 32'd4);
        idle(1'b1);
        enq(32'h6FFC, 32'h24010001);
        check("top_exc", 32'(d_exccode), 32'd0);
        check("top_instr", d_instr, 32'h24010001);
        idle(1'b1);

        // Delay-slot tagging after beq.
        enq(32'h3000, 32'h10000003);
        enq(32'h3004, 32'h24010001);
        check("beq_bd0", 32'(d_bd), 32'd0);
        idle(1'b1);
        check("beq_bd1", 32'(d_bd), 32'd1);
        enq(32'h3008, 32'h24020002);
        idle(1'b1);
        check("beq_bd2", 32'(d_bd), 32'd0);
        idle(1'b1);

        // Delay-slot tagging after jr.
        enq(32'h3000, 32'h03E00008);
        enq(32'h3004, 32'h24010001);
        check("jr_bd0", 32'(d_bd), 32'd0);
        idle(1'b1);
        check("jr_bd1", 32'(d_bd), 32'd1);
        idle(1'b1);

        // Flush from full with a branch pending in history.
        enq(32'h3000, 32'h24010001);
        enq(32'h3004, 32'h10000003);
        step(1'b0, 1'b1, 1'b1, 32'h3008, 32'h10000003, 1'b1);
        check("fl_d_valid", 32'(d_valid), 32'd0);
        check("fl_f_ready", 32'(f_ready), 32'd1);
        enq(32'h3010, 32'h10000003);
        enq(32'h3014, 32'h24010001);
        check("fl_bd0", 32'(d_bd), 32'd0);
        idle(1'b1);
        check("fl_bd1", 32'(d_bd), 32'd1);
        idle(1'b1);

        // Reset mid-stream with the queue full.
        enq(32'h3000, 32'h10000003);
        enq(32'h3004, 32'h24010001);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("mrst_d_valid", 32'(d_valid), 32'd0);
        check("mrst_f_ready", 32'(f_ready), 32'd1);
        idle(1'b0);

        // Bypass path into an empty queue.
        step(1'b0, 1'b0, 1'b1, 32'h3000, 32'h24010001, 1'b1);
        idle(1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       rpc = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2) + $urandom_range(1, 3);
                1:       rpc = 32'h2000 + ($urandom_range(0, 32'h3FF) << 2);
                2:       rpc = 32'h6FFC + ($urandom_range(1, 32'h400) << 2);
                default: rpc = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            endcase
            rins = $urandom;
            case ($urandom_range(0, 3))
                0:       rins[31:26] = br_ops[$urandom_range(0, 6)];
                1:       begin rins[31:26] = 6'h00; rins[5:0] = 6'($urandom_range(8, 9)); end
                default: rins = rins;
            endcase
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), rpc, rins, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
